// File: rtl/sd_ctrl_pkg.sv
// Shared encodings for the SD event/interrupt controller: edge select codes and the IRQ FSM states.
package sd_ctrl_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StAssert  = 2'b01,
    StHoldoff = 2'b10
  } irq_state_e;

endpackage

// File: rtl/edge_detect.sv
// Registered rise/fall detector for one level signal; pulses last one cycle after the sampling edge.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q, valid_q, rise_q, fall_q;

  // valid_q suppresses a pulse on the first sample after reset, so a level
  // that is already high at release is taken as history, not as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      valid_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      prev_q  <= sig_i;
      valid_q <= 1'b1;
      rise_q  <= valid_q & sig_i & ~prev_q;
      fall_q  <= valid_q & ~sig_i & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sd_event_irq_ctrl.sv
// Latches per-source edge events into status/overrun flags and drives a single
// interrupt line with acknowledge and a post-acknowledge holdoff window.
module sd_event_irq_ctrl
  import sd_ctrl_pkg::*;
#(
  parameter int unsigned NSRC = 4,
  parameter int unsigned HW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   src,
  input  logic [2*NSRC-1:0] edge_sel,
  input  logic [NSRC-1:0]   int_en,
  input  logic [NSRC-1:0]   clr,
  input  logic              irq_ack,
  input  logic [HW-1:0]     holdoff,
  output logic [NSRC-1:0]   status,
  output logic [NSRC-1:0]   overrun,
  output logic              irq
);

  logic [NSRC-1:0] rise, fall, evt;
  logic [NSRC-1:0] status_q, status_d, overrun_q, overrun_d;
  logic [HW-1:0]   cnt_q, cnt_d;
  irq_state_e      state_q, state_d;
  logic            irq_q;
  logic            pend;

  for (genvar i = 0; i < int'(NSRC); i++) begin : g_src
    logic [1:0] sel;
    assign sel = edge_sel[2*i +: 2];

    edge_detect u_edge_detect (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (src[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );

    assign evt[i] = (sel != EDGE_NONE) &
                    ((rise[i] & ((sel == EDGE_RISE) | (sel == EDGE_BOTH))) |
                     (fall[i] & ((sel == EDGE_FALL) | (sel == EDGE_BOTH))));
  end

  // A new event beats a same-cycle clear; the clear still wipes overrun.
  always_comb begin
    status_d  = evt | (status_q & ~clr);
    overrun_d = ~clr & (overrun_q | (evt & status_q));
  end

  assign pend = |(status_q & int_en);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pend) state_d = StAssert;
      end
      StAssert: begin
        if (irq_ack) begin
          if (holdoff != '0) begin
            state_d = StHoldoff;
            cnt_d   = holdoff;
          end else begin
            state_d = StIdle;
          end
        end else if (!pend) begin
          state_d = StIdle;
        end
      end
      StHoldoff: begin
        cnt_d = cnt_q - HW'(1);
        // The idle pend check is folded into the exit so irq is low exactly holdoff cycles.
        if (cnt_q == HW'(1)) state_d = pend ? StAssert : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q  <= '0;
      overrun_q <= '0;
      cnt_q     <= '0;
      state_q   <= StIdle;
      irq_q     <= 1'b0;
    end else begin
      status_q  <= status_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      irq_q     <= (state_d == StAssert);
    end
  end

  assign status  = status_q;
  assign overrun = overrun_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_sd_event_irq_ctrl.sv
// Directed bench for sd_event_irq_ctrl; outputs are sampled 1 ns after each rising edge.
module tb_sd_event_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src, int_en, clr, status, overrun;
  logic [7:0] edge_sel, holdoff;
  logic       irq_ack, irq;

  int compared   = 0;
  int mismatched = 0;

  sd_event_irq_ctrl #(.NSRC(4), .HW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .edge_sel (edge_sel),
    .int_en   (int_en),
    .clr      (clr),
    .irq_ack  (irq_ack),
    .holdoff  (holdoff),
    .status   (status),
    .overrun  (overrun),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; src = '0; edge_sel = '0; int_en = '0; clr = '0; irq_ack = 1'b0; holdoff = '0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (status !== 4'b0000) begin
      mismatched++; $display("FAIL reset_status: got %b want 0000", status);
    end
    compared++;
    if (overrun !== 4'b0000) begin
      mismatched++; $display("FAIL reset_overrun: got %b want 0000", overrun);
    end
    compared++;
    if (irq !== 1'b0) begin
      mismatched++; $display("FAIL reset_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_single_pulse();
    do_reset();
    edge_sel = 8'b0000_0001; int_en = 4'b0001;
    src = 4'b0001;
    tick();  // edge k
    compared++;
    if (status !== 4'b0000) begin
      mismatched++; $display("FAIL single_status_k: got %b want 0000", status);
    end
    tick();  // edge k+1
    compared++;
    if (status !== 4'b0001) begin
      mismatched++; $display("FAIL single_status_k1: got %b want 0001", status);
    end
    compared++;
    if (irq !== 1'b0) begin
      mismatched++; $display("FAIL single_irq_k1: got %b want 0", irq);
    end
    tick();  // edge k+2
    compared++;
    if (irq !== 1'b1) begin
      mismatched++; $display("FAIL single_irq_k2: got %b want 1", irq);
    end
    // Software clears the only enabled bit: irq drops without an acknowledge.
    clr = 4'b0001;
    tick();
    clr = 4'b0000;
    compared++;
    if (status !== 4'b0000) begin
      mismatched++; $display("FAIL single_clr_status: got %b want 0000", status);
    end
    tick();
    compared++;
    if (irq !== 1'b0) begin
      mismatched++; $display("FAIL single_clr_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_fall_only();
    do_reset();
    edge_sel = 8'b0000_1000; int_en = 4'b0010;
    src = 4'b0010;
    tick(); tick(); tick();
    compared++;
    if (status !== 4'b0000) begin
      mismatched++; $display("FAIL fall_no_rise: got %b want 0000", status);
    end
    src = 4'b0000;
    tick();
    compared++;
    if (status !== 4'b0000) begin
      mismatched++; $display("FAIL fall_status_f: got %b want 0000", status);
    end
    tick();
    compared++;
    if (status !== 4'b0010) begin
      mismatched++; $display("FAIL fall_status_f1: got %b want 0010", status);
    end
  endtask

  task automatic test_edge_none();
    do_reset();
    edge_sel = 8'b0000_0000; int_en = 4'b1111;
    src = 4'b1111; tick(); tick(); tick();
    src = 4'b0000; tick(); tick(); tick();
    compared++;
    if (status !== 4'b0000 || irq !== 1'b0) begin
      mismatched++; $display("FAIL edge_none: got status %b irq %b want 0000/0", status, irq);
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    edge_sel = 8'b0000_0001; int_en = 4'b0000;
    src = 4'b0001; tick(); tick();
    src = 4'b0000; tick();
    src = 4'b0001;
    tick();            // rise pulse present during the next cycle
    clr = 4'b0001;
    tick();
    clr = 4'b0000;
    compared++;
    if (status[0] !== 1'b1) begin
      mismatched++; $display("FAIL setwins_status: got %b want 1", status[0]);
    end
    compared++;
    if (overrun[0] !== 1'b0) begin
      mismatched++; $display("FAIL setwins_overrun: got %b want 0", overrun[0]);
    end
  endtask

  task automatic test_overrun_mask();
    do_reset();
    edge_sel = 8'b0001_0000; int_en = 4'b0000;
    src = 4'b0100; tick(); tick();
    src = 4'b0000; tick();
    src = 4'b0100; tick(); tick();
    compared++;
    if (status !== 4'b0100) begin
      mismatched++; $display("FAIL ovr_status: got %b want 0100", status);
    end
    compared++;
    if (overrun !== 4'b0100) begin
      mismatched++; $display("FAIL ovr_overrun: got %b want 0100", overrun);
    end
    compared++;
    if (irq !== 1'b0) begin
      mismatched++; $display("FAIL ovr_irq_masked: got %b want 0", irq);
    end
    clr = 4'b0100; tick(); clr = 4'b0000;
    compared++;
    if (status !== 4'b0000 || overrun !== 4'b0000) begin
      mismatched++; $display("FAIL ovr_clr: got %b/%b want 0000/0000", status, overrun);
    end
  endtask

  task automatic test_both_edges();
    do_reset();
    edge_sel = 8'b1100_0000; int_en = 4'b1000;
    src = 4'b1000; tick(); tick();
    compared++;
    if (status !== 4'b1000 || overrun !== 4'b0000) begin
      mismatched++; $display("FAIL both_rise: got %b/%b want 1000/0000", status, overrun);
    end
    src = 4'b0000; tick(); tick();
    compared++;
    if (overrun !== 4'b1000) begin
      mismatched++; $display("FAIL both_fall_ovr: got %b want 1000", overrun);
    end
  endtask

  task automatic test_holdoff();
    do_reset();
    edge_sel = 8'b0000_0001; int_en = 4'b0001; holdoff = 8'd5;
    src = 4'b0001; tick(); tick(); tick();
    src = 4'b0000;
    compared++;
    if (irq !== 1'b1) begin
      mismatched++; $display("FAIL hold_irq_pre: got %b want 1", irq);
    end
    irq_ack = 1'b1; clr = 4'b0001;
    tick();            // e0: enter holdoff
    irq_ack = 1'b0; clr = 4'b0000;
    src = 4'b0001;     // new event one cycle later
    compared++;
    if (irq !== 1'b0) begin
      mismatched++; $display("FAIL hold_low_0: got %b want 0", irq);
    end
    for (int c = 1; c < 5; c++) begin
      tick();
      compared++;
      if (irq !== 1'b0) begin
        mismatched++; $display("FAIL hold_low_%0d: got %b want 0", c, irq);
      end
    end
    compared++;
    if (status !== 4'b0001) begin
      mismatched++; $display("FAIL hold_status_latched: got %b want 0001", status);
    end
    tick();
    compared++;
    if (irq !== 1'b1) begin
      mismatched++; $display("FAIL hold_reassert: got %b want 1", irq);
    end
  endtask

  task automatic test_ack_zero_holdoff();
    do_reset();
    edge_sel = 8'b0000_0001; int_en = 4'b0001; holdoff = 8'd0;
    src = 4'b0001; tick(); tick(); tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    compared++;
    if (irq !== 1'b0) begin
      mismatched++; $display("FAIL ack0_drop: got %b want 0", irq);
    end
    tick();            // status still set: back to assert
    compared++;
    if (irq !== 1'b1) begin
      mismatched++; $display("FAIL ack0_reassert: got %b want 1", irq);
    end
    clr = 4'b0001; tick(); clr = 4'b0000; tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick();
    compared++;
    if (irq !== 1'b0) begin
      mismatched++; $display("FAIL ack_idle_ignored: got %b want 0", irq);
    end
  endtask

  task automatic test_reset_mid_assert();
    do_reset();
    edge_sel = 8'b0000_0001; int_en = 4'b0001;
    src = 4'b0001; tick(); tick(); tick();
    rst = 1'b1; tick();
    compared++;
    if (status !== 4'b0000 || overrun !== 4'b0000 || irq !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid: got %b/%b/%b want 0000/0000/0", status, overrun, irq);
    end
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    compared++;
    if (status !== 4'b0000 || irq !== 1'b0) begin
      mismatched++; $display("FAIL rst_no_spurious: got %b/%b want 0000/0", status, irq);
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_fall_only();
    test_edge_none();
    test_set_wins();
    test_overrun_mask();
    test_both_edges();
    test_holdoff();
    test_ack_zero_holdoff();
    test_reset_mid_assert();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sd_event_irq_ctrl.md
SD_EVENT_IRQ_CTRL -- requirements
Module: sd_event_irq_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 4, number of event sources.
REQ-002 SHALL have parameter HW, default 8, holdoff counter width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 src  in  NSRC  level event sources, e.g. cmd done, data done, card detect, FIFO error.
REQ-006 edge_sel  in  2*NSRC  per-source edge select: 00 none, 01 rise, 10 fall, 11 both.
REQ-007 int_en  in  NSRC  per-source interrupt enable.
REQ-008 clr  in  NSRC  write-1-to-clear strobe, one cycle per write.
REQ-009 irq_ack  in  1  single-cycle interrupt acknowledge.
REQ-010 holdoff  in  HW  minimum cycles irq stays low after an acknowledge.
REQ-011 status  out  NSRC  latched event flags.
REQ-012 overrun  out  NSRC  sticky flag: an event arrived while its status bit was already set.
REQ-013 irq  out  1  registered interrupt request.

Function
REQ-014 Edge detection per source SHALL be registered: a src change sampled at clock edge k SHALL produce a one-cycle rise or fall pulse during the cycle after edge k.
REQ-015 Event for source i = (rise_i & edge_sel[2i]) | (fall_i & edge_sel[2i+1]); edge_sel 00 SHALL never set status.
REQ-016 status[i] SHALL set at edge k+1 after the event and hold until cleared; it SHALL be set regardless of int_en.
REQ-017 clr[i]=1 SHALL clear status[i] and overrun[i] at the next edge.
REQ-018 If a new event and clr[i] occur in the same cycle, status[i] SHALL end set (set wins) and overrun[i] SHALL end clear.
REQ-019 overrun[i] SHALL set when an event for source i occurs while status[i]=1 and clr[i]=0.
REQ-020 pend = |(status & int_en), evaluated combinationally from registered status.
REQ-021 The FSM SHALL have three states: IDLE, ASSERT, HOLDOFF; irq SHALL be 1 only in ASSERT, driven from a register.
REQ-022 IDLE -> ASSERT when pend=1; irq SHALL therefore go high at edge k+2 for an enabled event sampled at edge k.
REQ-023 ASSERT -> HOLDOFF on irq_ack=1 with holdoff!=0, loading the counter with holdoff.
REQ-024 ASSERT -> IDLE on irq_ack=1 with holdoff=0.
REQ-025 ASSERT -> IDLE when pend=0 without an acknowledge, i.e. software cleared all enabled status bits.
REQ-026 HOLDOFF SHALL decrement the counter each cycle and go to IDLE in the cycle the counter equals 1; irq SHALL stay low for exactly holdoff cycles.
REQ-027 Events during HOLDOFF SHALL still latch into status; irq SHALL re-assert at the first IDLE evaluation with pend=1.
REQ-028 irq_ack received in IDLE or HOLDOFF SHALL be ignored.
REQ-029 A change of int_en SHALL affect pend in the same cycle; a change of holdoff SHALL take effect only at the next load.

Reset
REQ-030 rst=1 SHALL, at the next edge, clear status, overrun, the holdoff counter and the edge-detector history, set the FSM to IDLE and drive irq=0.
REQ-031 Reset asserted mid-operation, in ASSERT or HOLDOFF, SHALL abort to IDLE with no residual pending event.
REQ-032 A src level already high at reset release SHALL NOT generate a rise event.

Structure
REQ-033 A shared package sd_ctrl_pkg SHALL hold the edge_sel encodings EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH and the FSM state enum.
REQ-034 The design SHALL instantiate the existing edge_detect sub-module once per source through a generate loop; no other sub-module.

Verification
REQ-035 Single pulse: rst released, int_en=0001, edge_sel[1:0]=01, src[0] 0->1 at edge k -> status=0001 after edge k+1, irq=1 after edge k+2.
REQ-036 Fall only: edge_sel[3:2]=10, src[1] 0->1->0 -> no status on the rise; status[1]=1 two edges after the fall.
REQ-037 Set-wins: clr[0]=1 in the same cycle as a new src[0] event -> status[0]=1, overrun[0]=0.
REQ-038 Holdoff: holdoff=5, irq_ack while irq=1, new event 1 cycle later -> irq low exactly 5 cycles, then high in the next cycle.
REQ-039 Overrun plus mask: two src[2] rises without clr, int_en[2]=0 -> status[2]=1, overrun[2]=1, irq stays 0.
REQ-040 Reset mid-ASSERT: rst pulsed while irq=1 -> status=0, overrun=0, irq=0 after one edge; no spurious event with src held high.
